// File: rtl/time_set_ctrl.sv
// time_set_ctrl: time-setting controller for a BCD clock.
//
// A MODE press in RUN copies the running time into an edit register and enters SET_H.
// Further MODE presses step through SET_M, SET_S and a single-cycle COMMIT. COMMIT
// strobes PE so the timer loads D_H/D_M/D_S. While a field is selected, UP/DOWN
// presses increment or decrement it in BCD with wraparound. BLINK blanks the selected
// field on a 1 Hz phase.
//
// Ports:
//   CP        in   system clock, rising edge
//   CR        in   synchronous active-high reset
//   TICK_1HZ  in   one-cycle enable, once per second
//   KEY_MODE  in   debounced key levels, active-high
//   KEY_UP    in
//   KEY_DOWN  in
//   Q_H/M/S   in   running time, BCD {tens,ones}
//   D_H/M/S   out  edit/preset time, BCD
//   PE        out  parallel-load strobe (COMMIT cycle only)
//   MODE      out  0=RUN/COMMIT, 1=SET_H, 2=SET_M, 3=SET_S
//   BLINK     out  blank mask {H,M,S}
//
// Optional feature: define SET_TIMEOUT_EN to abandon an edit after 10 idle seconds.
module time_set_ctrl (
    input  logic       CP,
    input  logic       CR,
    input  logic       TICK_1HZ,
    input  logic       KEY_MODE,
    input  logic       KEY_UP,
    input  logic       KEY_DOWN,
    input  logic [7:0] Q_H,
    input  logic [7:0] Q_M,
    input  logic [7:0] Q_S,
    output logic [7:0] D_H,
    output logic [7:0] D_M,
    output logic [7:0] D_S,
    output logic       PE,
    output logic [1:0] MODE,
    output logic [2:0] BLINK
);

    typedef enum logic [2:0] {StRun, StSetH, StSetM, StSetS, StCommit} state_e;

    state_e     state_q, state_d;
    logic [7:0] h_q, h_d, m_q, m_d, s_q, s_d;
    logic       phase_q, phase_d;
    logic       mode_prev_q, up_prev_q, down_prev_q;
    logic       mode_press, up_press, down_press;
    logic       in_set, edit_up, edit_down, timeout;

    // The field value is legal BCD in 00..max.
    function automatic logic bcd_legal(input logic [7:0] v, input logic [7:0] max);
        return (v[3:0] <= 4'd9) && (v <= max);
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v >= max) return 8'h00;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return v + 8'd1;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
        if (v == 8'h00) return max;
        if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        return v - 8'd1;
    endfunction

    assign mode_press = KEY_MODE & ~mode_prev_q;
    assign up_press   = KEY_UP & ~up_prev_q;
    assign down_press = KEY_DOWN & ~down_prev_q;
    assign in_set     = (state_q == StSetH) || (state_q == StSetM) || (state_q == StSetS);

`ifdef SET_TIMEOUT_EN
    logic [3:0] idle_q, idle_d;

    assign timeout = in_set && (idle_q == 4'd10);

    always_comb begin
        idle_d = idle_q;
        if ((state_d != state_q) || mode_press || up_press || down_press) begin
            idle_d = 4'd0;
        end else if (TICK_1HZ && in_set) begin
            idle_d = idle_q + 4'd1;
        end
    end

    always_ff @(posedge CP) begin
        if (CR) idle_q <= 4'd0;
        else    idle_q <= idle_d;
    end
`else
    assign timeout = 1'b0;
`endif

    // A MODE press or a timeout takes priority; a simultaneous UP+DOWN cancels out.
    assign edit_up   = in_set & up_press & ~down_press & ~mode_press & ~timeout;
    assign edit_down = in_set & down_press & ~up_press & ~mode_press & ~timeout;

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        m_d     = m_q;
        s_d     = s_q;
        phase_d = phase_q;

        unique case (state_q)
            StRun: begin
                if (mode_press) begin
                    state_d = StSetH;
                    h_d     = bcd_legal(Q_H, 8'h23) ? Q_H : 8'h00;
                    m_d     = bcd_legal(Q_M, 8'h59) ? Q_M : 8'h00;
                    s_d     = bcd_legal(Q_S, 8'h59) ? Q_S : 8'h00;
                end
            end
            StSetH: begin
                if (timeout)         state_d = StRun;
                else if (mode_press) state_d = StSetM;
            end
            StSetM: begin
                if (timeout)         state_d = StRun;
                else if (mode_press) state_d = StSetS;
            end
            StSetS: begin
                if (timeout)         state_d = StRun;
                else if (mode_press) state_d = StCommit;
            end
            StCommit: state_d = StRun;
            default:  state_d = StRun;
        endcase

        if (edit_up || edit_down) begin
            unique case (state_q)
                StSetH:  h_d = edit_up ? bcd_inc(h_q, 8'h23) : bcd_dec(h_q, 8'h23);
                StSetM:  m_d = edit_up ? bcd_inc(m_q, 8'h59) : bcd_dec(m_q, 8'h59);
                StSetS:  s_d = edit_up ? bcd_inc(s_q, 8'h59) : bcd_dec(s_q, 8'h59);
                default: ;
            endcase
        end

        // An edit forces the field visible; the phase only runs while editing.
        if (!(state_d inside {StSetH, StSetM, StSetS})) begin
            phase_d = 1'b0;
        end else if (edit_up || edit_down) begin
            phase_d = 1'b0;
        end else if (TICK_1HZ && in_set) begin
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge CP) begin
        if (CR) begin
            state_q     <= StRun;
            h_q         <= 8'h00;
            m_q         <= 8'h00;
            s_q         <= 8'h00;
            phase_q     <= 1'b0;
            mode_prev_q <= 1'b0;
            up_prev_q   <= 1'b0;
            down_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            m_q         <= m_d;
            s_q         <= s_d;
            phase_q     <= phase_d;
            mode_prev_q <= KEY_MODE;
            up_prev_q   <= KEY_UP;
            down_prev_q <= KEY_DOWN;
        end
    end

    always_comb begin
        MODE  = 2'd0;
        BLINK = 3'b000;
        unique case (state_q)
            StSetH:  begin MODE = 2'd1; BLINK = {phase_q, 2'b00};       end
            StSetM:  begin MODE = 2'd2; BLINK = {1'b0, phase_q, 1'b0};  end
            StSetS:  begin MODE = 2'd3; BLINK = {2'b00, phase_q};       end
            default: ;
        endcase
    end

    assign PE  = (state_q == StCommit);
    assign D_H = h_q;
    assign D_M = m_q;
    assign D_S = s_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: directed scenarios plus a randomized run,
// all compared against an integer-arithmetic reference model.
module tb_time_set_ctrl;

    logic       cp = 1'b0;
    logic       cr, tick, k_mode, k_up, k_down;
    logic [7:0] q_h, q_m, q_s;
    logic [7:0] d_h, d_m, d_s;
    logic       pe;
    logic [1:0] mode;
    logic [2:0] blink;

    int checks = 0;
    int errors = 0;
    int pe_seen = 0;

    always #5 cp = ~cp;

    time_set_ctrl u_dut (
        .CP       (cp),
        .CR       (cr),
        .TICK_1HZ (tick),
        .KEY_MODE (k_mode),
        .KEY_UP   (k_up),
        .KEY_DOWN (k_down),
        .Q_H      (q_h),
        .Q_M      (q_m),
        .Q_S      (q_s),
        .D_H      (d_h),
        .D_M      (d_m),
        .D_S      (d_s),
        .PE       (pe),
        .MODE     (mode),
        .BLINK    (blink)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: state 0=RUN, 1..3=SET_H/M/S, 4=COMMIT; fields as plain integers.
    int ms = 0, mh = 0, mm = 0, msec = 0, midle = 0;
    bit mph = 0, pm_prev = 0, pu_prev = 0, pd_prev = 0;

    function automatic int sanitize(input logic [7:0] v, input int maxv);
        int t = int'(v[7:4]);
        int o = int'(v[3:0]);
        if (o > 9 || t * 10 + o > maxv) return 0;
        return t * 10 + o;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic model_step();
        bit pm = k_mode && !pm_prev;
        bit pu = k_up && !pu_prev;
        bit pd = k_down && !pd_prev;
        bit in_set = (ms >= 1 && ms <= 3);
        bit to = 0;
        bit ed = 0;
        int ns = ms;
        int delta;
        pm_prev = k_mode;
        pu_prev = k_up;
        pd_prev = k_down;
        if (cr) begin
            ms = 0; mh = 0; mm = 0; msec = 0; mph = 0; midle = 0;
            pm_prev = 0; pu_prev = 0; pd_prev = 0;
            return;
        end
`ifdef SET_TIMEOUT_EN
        to = in_set && midle == 10;
`endif
        if (ms == 0) begin
            if (pm) begin
                ns = 1;
                mh = sanitize(q_h, 23);
                mm = sanitize(q_m, 59);
                msec = sanitize(q_s, 59);
            end
        end else if (ms == 4) begin
            ns = 0;
        end else if (to) begin
            ns = 0;
        end else if (pm) begin
            ns = ms + 1;
        end else if (pu != pd) begin
            ed = 1;
            delta = pu ? 1 : -1;
            case (ms)
                1: mh = (mh + delta + 24) % 24;
                2: mm = (mm + delta + 60) % 60;
                default: msec = (msec + delta + 60) % 60;
            endcase
        end
        if (!(ns >= 1 && ns <= 3)) mph = 0;
        else if (ed) mph = 0;
        else if (tick && in_set) mph = !mph;
        if (ns != ms || pm || pu || pd) midle = 0;
        else if (tick && in_set) midle++;
        ms = ns;
    endtask

    task automatic compare_all();
        logic [2:0] eb = 3'b000;
        if (ms >= 1 && ms <= 3 && mph) eb = 3'b100 >> (ms - 1);
        check("mode",  32'(mode),  (ms >= 1 && ms <= 3) ? ms : 0);
        check("pe",    32'(pe),    32'(ms == 4));
        check("blink", 32'(blink), 32'(eb));
        check("d_h",   32'(d_h),   32'(to_bcd(mh)));
        check("d_m",   32'(d_m),   32'(to_bcd(mm)));
        check("d_s",   32'(d_s),   32'(to_bcd(msec)));
    endtask

    task automatic cyc(input bit m, input bit u, input bit d, input bit t, input bit r);
        k_mode = m; k_up = u; k_down = d; tick = t; cr = r;
        @(posedge cp);
        model_step();
        #1;
        if (pe) pe_seen++;
        compare_all();
    endtask

    task automatic press(input bit m, input bit u, input bit d);
        cyc(m, u, d, 0, 0);
        cyc(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
    endtask

    task automatic set_q(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        q_h = h; q_m = m; q_s = s;
    endtask

    initial begin
        int pe_cnt;
        logic [23:0] commit_d;
        bit quiet;
        cr = 1; tick = 0; k_mode = 0; k_up = 0; k_down = 0;
        set_q(8'h12, 8'h34, 8'h56);

        // Reset then MODE loads the running time.
        do_reset();
        check("rst_mode", 32'(mode), 0);
        check("rst_d", 32'({d_h, d_m, d_s}), 32'h000000);
        check("rst_pe", 32'(pe), 0);
        check("rst_blink", 32'(blink), 0);
        press(1, 0, 0);
        check("load_mode", 32'(mode), 1);
        check("load_d", 32'({d_h, d_m, d_s}), 32'h123456);
        check("load_pe", 32'(pe), 0);

        // Hour wrap both ways, blink phase cleared by an edit.
        set_q(8'h23, 8'h45, 8'h00);
        do_reset();
        press(1, 0, 0);
        check("h_load", 32'(d_h), 32'h23);
        cyc(0, 0, 0, 1, 0);
        check("blink_h", 32'(blink), 32'b100);
        press(0, 1, 0);
        check("h_wrap_up", 32'(d_h), 32'h00);
        check("blink_clr", 32'(blink), 0);
        check("h_up_ms", 32'({d_m, d_s}), 32'h4500);
        press(0, 0, 1);
        check("h_wrap_dn", 32'(d_h), 32'h23);
        press(1, 0, 0);
        press(1, 0, 0);
        check("set_s_mode", 32'(mode), 3);
        press(0, 0, 1);
        check("s_wrap_dn", 32'(d_s), 32'h59);
        press(0, 1, 1);
        check("s_updn", 32'(d_s), 32'h59);

        // Commit: exactly one PE cycle carrying the final value.
        pe_cnt = 0;
        commit_d = 24'h0;
        cyc(1, 0, 0, 0, 0);
        if (pe) begin pe_cnt++; commit_d = {d_h, d_m, d_s}; end
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 0);
            if (pe) begin pe_cnt++; commit_d = {d_h, d_m, d_s}; end
        end
        check("pe_count", 32'(pe_cnt), 1);
        check("commit_d", 32'(commit_d), 32'h234559);
        check("after_commit", 32'(mode), 0);
        check("hold_d", 32'({d_h, d_m, d_s}), 32'h234559);

        // Reset during SET_M abandons the edit.
        set_q(8'h01, 8'h02, 8'h03);
        do_reset();
        press(1, 0, 0);
        press(1, 0, 0);
        check("cr_setm", 32'(mode), 2);
        pe_seen = 0;
        cyc(0, 0, 0, 0, 1);
        check("cr_mode", 32'(mode), 0);
        check("cr_d", 32'({d_h, d_m, d_s}), 32'h000000);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
        check("cr_no_pe", 32'(pe_seen), 0);

        // Idle behaviour in SET_M.
        set_q(8'h10, 8'h20, 8'h30);
        do_reset();
        press(1, 0, 0);
        press(1, 0, 0);
        pe_seen = 0;
`ifdef SET_TIMEOUT_EN
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0, 1, 0);
            cyc(0, 0, 0, 0, 0);
        end
        cyc(0, 0, 0, 0, 0);
        check("to_mode", 32'(mode), 0);
        check("to_no_pe", 32'(pe_seen), 0);
        do_reset();
        press(1, 0, 0);
        press(1, 0, 0);
        for (int i = 0; i < 9; i++) begin
            cyc(0, 0, 0, 1, 0);
            cyc(0, 0, 0, 0, 0);
        end
        press(0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 1, 0);
            cyc(0, 0, 0, 0, 0);
        end
        check("to_kept", 32'(mode), 2);
        check("to_kept_m", 32'(d_m), 32'h21);
`else
        for (int i = 0; i < 12; i++) begin
            cyc(0, 0, 0, 1, 0);
            cyc(0, 0, 0, 0, 0);
        end
        check("no_to_mode", 32'(mode), 2);
        check("no_to_pe", 32'(pe_seen), 0);
`endif

        // Randomized run with occasional quiet stretches so idle counting is exercised.
        do_reset();
        quiet = 0;
        for (int i = 0; i < 3000; i++) begin
            bit m = k_mode, u = k_up, d = k_down;
            if (i % 40 == 0) begin
                if ($urandom_range(0, 1) == 0)
                    set_q(to_bcd($urandom_range(0, 23)), to_bcd($urandom_range(0, 59)),
                          to_bcd($urandom_range(0, 59)));
                else
                    set_q(8'($urandom), 8'($urandom), 8'($urandom));
            end
            if (i % 500 == 0) quiet = 1;
            if (i % 500 == 150) quiet = 0;
            if (!quiet) begin
                if ($urandom_range(0, 7) == 0) m = !m;
                if ($urandom_range(0, 4) == 0) u = !u;
                if ($urandom_range(0, 4) == 0) d = !d;
            end
            cyc(m, u, d, $urandom_range(0, 5) == 0, $urandom_range(0, 299) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
